// File: rtl/rn_pkt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rn_pkt_scheduler
// Brief    : Round-robin AXI4-Stream packet merger with per-source counters.
// Revision : 1.0
// ============================================================================
module rn_pkt_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 512,
    parameter int CNT_W   = 32
) (
    input  logic                         axis_aclk,
    input  logic                         axis_rst,
    input  logic [NUM_SRC-1:0]           s_axis_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0]    s_axis_tdata,
    input  logic [NUM_SRC*DATA_W/8-1:0]  s_axis_tkeep,
    input  logic [NUM_SRC-1:0]           s_axis_tlast,
    output logic [NUM_SRC-1:0]           s_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic [DATA_W/8-1:0]          m_axis_tkeep,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    input  logic [NUM_SRC-1:0]           src_enable,
    input  logic                         cnt_clear,
    output logic [NUM_SRC*CNT_W-1:0]     pkt_cnt,
    output logic                         busy
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_SRC - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   w_rr_pick;
    logic [IDX_W-1:0]   w_rr_cand;
    int                 w_rr_idx;
    logic               w_rr_found;
    logic [NUM_SRC-1:0] w_elig;
    logic [DATA_W-1:0]  w_src_data [NUM_SRC];
    logic [KEEP_W-1:0]  w_src_keep [NUM_SRC];
    logic [CNT_W-1:0]   r_pkt_cnt  [NUM_SRC];
    logic               w_in_xfer;
    logic               w_beat;
    logic               w_pkt_done;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            assign w_src_data[g]             = s_axis_tdata[g*DATA_W +: DATA_W];
            assign w_src_keep[g]             = s_axis_tkeep[g*KEEP_W +: KEEP_W];
            assign pkt_cnt[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
        end
    endgenerate

    assign w_elig = s_axis_tvalid & src_enable;

    // Search starts one past the previous winner so every source gets a turn.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_pick  = '0;
        w_rr_idx   = 0;
        w_rr_cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_rr_idx  = (int'(r_last_grant) + k) % NUM_SRC;
            w_rr_cand = IDX_W'(w_rr_idx);
            if (!w_rr_found && w_elig[w_rr_cand]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_rr_cand;
            end
        end
    end

    assign w_in_xfer     = (r_state == ST_XFER);
    assign busy          = w_in_xfer;
    assign m_axis_tvalid = w_in_xfer & s_axis_tvalid[r_grant];
    assign m_axis_tdata  = w_in_xfer ? w_src_data[r_grant] : '0;
    assign m_axis_tkeep  = w_in_xfer ? w_src_keep[r_grant] : '0;
    assign m_axis_tlast  = w_in_xfer & s_axis_tlast[r_grant];
    assign w_beat        = m_axis_tvalid & m_axis_tready;
    assign w_pkt_done    = w_beat & m_axis_tlast;

    always_comb begin
        s_axis_tready = '0;
        if (w_in_xfer) begin
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_state_nxt = ST_XFER;
                    w_grant_nxt = w_rr_pick;
                end
            end
            ST_XFER: begin
                if (w_pkt_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= C_LAST_IDX;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_pkt_done) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Clear takes priority over a coincident end-of-packet increment.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cnt_clear) begin
                    r_pkt_cnt[i] <= '0;
                end else if (w_pkt_done && (r_grant == IDX_W'(i))) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rn_pkt_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rn_pkt_scheduler
// Brief    : Scoreboard bench for rn_pkt_scheduler with a packet-level model.
// Revision : 1.0
// ============================================================================
module tb_rn_pkt_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 32;
    localparam int KEEP_W  = DATA_W / 8;
    localparam int CNT_W   = 4;
    localparam int BEAT_W  = DATA_W + KEEP_W + 1;

    typedef logic [BEAT_W-1:0] beat_t;   // {last, keep, data}

    logic                        axis_aclk = 1'b0;
    logic                        axis_rst  = 1'b1;
    logic [NUM_SRC-1:0]          s_axis_tvalid = '0;
    logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata  = '0;
    logic [NUM_SRC*KEEP_W-1:0]   s_axis_tkeep  = '0;
    logic [NUM_SRC-1:0]          s_axis_tlast  = '0;
    logic [NUM_SRC-1:0]          s_axis_tready;
    logic                        m_axis_tvalid;
    logic [DATA_W-1:0]           m_axis_tdata;
    logic [KEEP_W-1:0]           m_axis_tkeep;
    logic                        m_axis_tlast;
    logic                        m_axis_tready = 1'b1;
    logic [NUM_SRC-1:0]          src_enable = '1;
    logic                        cnt_clear  = 1'b0;
    logic [NUM_SRC*CNT_W-1:0]    pkt_cnt;
    logic                        busy;

    rn_pkt_scheduler #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .axis_aclk     (axis_aclk),
        .axis_rst      (axis_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .src_enable    (src_enable),
        .cnt_clear     (cnt_clear),
        .pkt_cnt       (pkt_cnt),
        .busy          (busy)
    );

    always #5 axis_aclk = ~axis_aclk;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t drv_q [NUM_SRC][$];
    beat_t exp_q [NUM_SRC][$];
    int    valid_pct = 100;
    int    trdy_mode = 0;       // 0: always ready, 1: toggle, 2: random
    int    seq = 0;

    // Reference model: a packet owner, the previous winner and per-source totals.
    bit               m_idle = 1'b1;
    int               m_last = NUM_SRC - 1;
    int               m_grant = 0;
    logic [CNT_W-1:0] m_cnt [NUM_SRC];
    int               grant_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge axis_aclk);
        #2;
    endtask

    task automatic send_pkt(input int src, input int nbeats);
        beat_t b;
        logic [7:0]  s8;
        logic [23:0] q24;
        for (int k = 0; k < nbeats; k++) begin
            s8  = 8'(src);
            q24 = 24'(seq);
            seq++;
            b = {(k == nbeats - 1), KEEP_W'($urandom), s8, q24};
            drv_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_SRC; i++) if (exp_q[i].size() != 0) return 1'b1;
        return !m_idle;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            cyc(1);
            n++;
        end
        chk("drain_timeout", (n >= budget), 0);
        cyc(2);
    endtask

    task automatic wait_exp_le(input int src, input int lim);
        int n = 0;
        while (exp_q[src].size() > lim && n < 100) begin
            cyc(1);
            n++;
        end
        chk("beat_wait_timeout", (n >= 100), 0);
    endtask

    task automatic pulse_clear();
        cnt_clear = 1'b1;
        cyc(1);
        cnt_clear = 1'b0;
    endtask

    // Source/sink driver: handshakes are decided before the edge, applied after it.
    initial begin : driver
        logic [NUM_SRC-1:0] hs;
        beat_t b;
        forever begin
            @(negedge axis_aclk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge axis_aclk);
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hs[i] && !axis_rst && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
                if (drv_q[i].size() > 0 && $urandom_range(99) < valid_pct) begin
                    b = drv_q[i][0];
                    s_axis_tvalid[i] = 1'b1;
                    s_axis_tdata[i*DATA_W +: DATA_W] = b[DATA_W-1:0];
                    s_axis_tkeep[i*KEEP_W +: KEEP_W] = b[DATA_W +: KEEP_W];
                    s_axis_tlast[i] = b[BEAT_W-1];
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i]  = 1'b0;
                end
            end
            case (trdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = ($urandom_range(99) < 70);
            endcase
        end
    end

    // Monitor: checks the current cycle, then advances the model across the next edge.
    always @(negedge axis_aclk) begin : monitor
        logic [NUM_SRC-1:0] elig;
        logic [NUM_SRC-1:0] exp_rdy;
        beat_t b;
        bit found;
        if (axis_rst) begin
            m_idle = 1'b1;
            m_last = NUM_SRC - 1;
            for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = '0;
            chk("rst_m_tvalid", m_axis_tvalid, 0);
            chk("rst_s_tready", s_axis_tready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_pkt_cnt", pkt_cnt, 0);
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                chk($sformatf("pkt_cnt%0d", i), pkt_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
            chk("busy", busy, !m_idle);
            if (m_idle) begin
                chk("idle_m_tvalid", m_axis_tvalid, 0);
                chk("idle_s_tready", s_axis_tready, 0);
                elig  = s_axis_tvalid & src_enable;
                found = 1'b0;
                for (int k = 1; k <= NUM_SRC; k++) begin
                    if (!found && elig[(m_last + k) % NUM_SRC]) begin
                        found   = 1'b1;
                        m_grant = (m_last + k) % NUM_SRC;
                    end
                end
                if (found) begin
                    m_idle = 1'b0;
                    grant_log.push_back(m_grant);
                end
            end else begin
                exp_rdy = '0;
                if (m_axis_tready) exp_rdy[m_grant] = 1'b1;
                chk("s_tready", s_axis_tready, exp_rdy);
                chk("m_tvalid", m_axis_tvalid, s_axis_tvalid[m_grant]);
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("extra_beat", (exp_q[m_grant].size() == 0), 0);
                    if (exp_q[m_grant].size() != 0) begin
                        b = exp_q[m_grant].pop_front();
                        chk("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, b);
                        if (b[BEAT_W-1]) begin
                            m_cnt[m_grant] = m_cnt[m_grant] + 1'b1;
                            m_last = m_grant;
                            m_idle = 1'b1;
                        end
                    end
                end
            end
            if (cnt_clear) for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = '0;
        end
    end

    initial begin : main
        int g0;
        for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = '0;
        cyc(3);
        chk("reset_m_tvalid", m_axis_tvalid, 0);
        chk("reset_busy", busy, 0);
        axis_rst = 1'b0;

        // Continuous single-beat traffic from every source rotates 0,1,2,3,...
        grant_log.delete();
        repeat (2) for (int i = 0; i < NUM_SRC; i++) send_pkt(i, 1);
        wait_drain(200);
        for (int i = 0; i < NUM_SRC; i++) chk($sformatf("rr_cnt%0d", i), pkt_cnt[i*CNT_W +: CNT_W], 2);
        for (int i = 0; i < 8; i++) begin
            g0 = (grant_log.size() > i) ? grant_log[i] : -1;
            chk($sformatf("rr_order%0d", i), g0, i % NUM_SRC);
        end

        // Two competing 3-beat packets.
        pulse_clear();
        send_pkt(0, 3);
        send_pkt(2, 3);
        wait_drain(200);
        chk("two_src_cnt0", pkt_cnt[0 +: CNT_W], 1);
        chk("two_src_cnt2", pkt_cnt[2*CNT_W +: CNT_W], 1);

        // Back-pressure toggling on a 4-beat packet.
        trdy_mode = 1;
        send_pkt(1, 4);
        wait_drain(200);
        trdy_mode = 0;

        // Disabling the granted source mid-packet.
        send_pkt(1, 4);
        wait_exp_le(1, 3);
        src_enable[1] = 1'b0;
        send_pkt(1, 2);
        send_pkt(0, 1);
        wait_exp_le(0, 0);
        cyc(6);
        chk("disabled_src_held", exp_q[1].size(), 2);
        src_enable[1] = 1'b1;
        wait_drain(200);

        // Counter wrap and clear-versus-increment priority.
        pulse_clear();
        repeat (15) send_pkt(0, 1);
        wait_drain(300);
        chk("cnt_preload", pkt_cnt[0 +: CNT_W], 15);
        send_pkt(0, 1);
        wait_drain(100);
        chk("cnt_wrap", pkt_cnt[0 +: CNT_W], 0);
        send_pkt(0, 1);
        wait_drain(100);
        chk("cnt_after_wrap", pkt_cnt[0 +: CNT_W], 1);
        send_pkt(2, 1);
        cyc(2);
        cnt_clear = 1'b1;
        cyc(1);
        cnt_clear = 1'b0;
        cyc(3);
        chk("clear_wins_cnt2", pkt_cnt[2*CNT_W +: CNT_W], 0);
        chk("clear_wins_cnt0", pkt_cnt[0 +: CNT_W], 0);

        // Reset in the middle of a source-3 packet.
        send_pkt(3, 4);
        wait_exp_le(3, 3);
        axis_rst = 1'b1;
        #1;
        chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_s_tready", s_axis_tready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt3", pkt_cnt[3*CNT_W +: CNT_W], 0);
        for (int i = 0; i < NUM_SRC; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        cyc(2);
        axis_rst = 1'b0;
        grant_log.delete();
        send_pkt(3, 1);
        send_pkt(1, 1);
        wait_drain(100);
        g0 = (grant_log.size() > 0) ? grant_log[0] : -1;
        chk("post_rst_first_grant", g0, 1);

        // Randomized traffic, enables, back-pressure and clears.
        valid_pct = 70;
        trdy_mode = 2;
        repeat (40) begin
            send_pkt($urandom_range(NUM_SRC - 1), $urandom_range(1, 5));
            src_enable = NUM_SRC'($urandom);
            cnt_clear  = ($urandom_range(9) == 0);
            cyc($urandom_range(1, 8));
            cnt_clear  = 1'b0;
        end
        src_enable = '1;
        wait_drain(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
